// File: rtl/axb_wr_slv_resp.sv
// AXB crossbar slave-port write responder: queues AW requests, sinks W
// bursts into a registered memory write port and returns one B per burst.
module axb_wr_slv_resp #(
    parameter int ID_W = 7,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W = 4,
    parameter int OT_DEPTH = 4,
    parameter logic [ADDR_W-1:0] ADDR_LO = 16'h0000,
    parameter logic [ADDR_W-1:0] ADDR_HI = 16'h0FFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [ID_W-1:0]   aw_id,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic [LEN_W-1:0]  aw_len,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_last,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [ID_W-1:0]   b_id,
    output logic [1:0]        b_resp,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        err_cnt
);

    localparam int SHIFT = $clog2(DATA_W / 8);
    localparam int PTR_W = $clog2(OT_DEPTH);

    typedef enum logic {
        IDLE,
        DATA
    } state_t;

    state_t state;

    logic [ID_W-1:0]   q_id   [OT_DEPTH];
    logic [LEN_W-1:0]  q_len  [OT_DEPTH];
    logic [ADDR_W-1:0] q_addr [OT_DEPTH];
    logic [OT_DEPTH-1:0] q_dec;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             alive;
    logic             full;
    logic             push;

    logic [LEN_W-1:0] beat;
    logic             lerr;

    logic [ID_W-1:0]   head_id;
    logic [LEN_W-1:0]  head_len;
    logic [ADDR_W-1:0] head_addr;
    logic              head_dec;

    logic              last_beat;
    logic              w_hs;
    logic              fin;
    logic              mism;
    logic [1:0]        resp_nxt;
    logic [ADDR_W-1:0] beat_off;

    logic [ADDR_W:0]   len_ext;
    logic [ADDR_W:0]   aw_last;
    logic [ADDR_W:0]   lo_diff;
    logic [ADDR_W+1:0] hi_diff;
    logic              aw_dec;

    // Range decode done with borrow bits so neither bound folds to a constant compare
    assign len_ext = {{(ADDR_W + 1 - LEN_W){1'b0}}, aw_len};
    assign aw_last = {1'b0, aw_addr} + (len_ext << SHIFT);
    assign lo_diff = {1'b0, aw_addr} - {1'b0, ADDR_LO};
    assign hi_diff = {2'b00, ADDR_HI} - {1'b0, aw_last};
    assign aw_dec  = lo_diff[ADDR_W] | hi_diff[ADDR_W+1];

    assign full     = (count == (PTR_W + 1)'(OT_DEPTH));
    assign aw_ready = alive & ~full;
    assign push     = aw_valid & aw_ready;

    assign head_id   = q_id[rd_ptr];
    assign head_len  = q_len[rd_ptr];
    assign head_addr = q_addr[rd_ptr];
    assign head_dec  = q_dec[rd_ptr];

    assign last_beat = (beat == head_len);
    assign w_ready   = (state == DATA) & (~last_beat | ~b_valid | b_ready);
    assign w_hs      = w_valid & w_ready;
    assign fin       = w_hs & last_beat;
    assign mism      = w_last ^ last_beat;
    assign beat_off  = {{(ADDR_W - LEN_W){1'b0}}, beat} << SHIFT;

    always_comb begin
        resp_nxt = 2'b00;
        if (head_dec) begin
            resp_nxt = 2'b11;
        end else if (lerr | mism) begin
            resp_nxt = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_id[wr_ptr]   <= aw_id;
            q_len[wr_ptr]  <= aw_len;
            q_addr[wr_ptr] <= aw_addr;
            q_dec[wr_ptr]  <= aw_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            alive     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            beat      <= '0;
            lerr      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            b_valid   <= 1'b0;
            b_id      <= '0;
            b_resp    <= 2'b00;
            err_cnt   <= 8'd0;
        end else begin
            alive <= 1'b1;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fin) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push & ~fin) begin
                count <= count + 1'b1;
            end else if (~push & fin) begin
                count <= count - 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (push) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (fin & ~push & (count == (PTR_W + 1)'(1))) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (w_hs) begin
                if (last_beat) begin
                    beat <= '0;
                    lerr <= 1'b0;
                end else begin
                    beat <= beat + 1'b1;
                    lerr <= lerr | mism;
                end
                mem_addr  <= head_addr + beat_off;
                mem_wdata <= w_data;
            end
            mem_we <= w_hs & ~head_dec;

            // Slot frees on accept; a new response may overwrite it in the same cycle
            if (b_valid & b_ready) begin
                b_valid <= 1'b0;
            end
            if (fin) begin
                b_valid <= 1'b1;
                b_id    <= head_id;
                b_resp  <= resp_nxt;
                if ((resp_nxt != 2'b00) && (err_cnt != 8'hFF)) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/axb_wr_slv_resp.md
Name: axb_wr_slv_resp

Overview:
Write-channel responder that terminates one slave-side port of the AXB crossbar. It accepts AW requests carrying the crossbar-widened ID and sinks W bursts into a simple memory write port. It returns one B response per burst, echoing the ID. It is the far end of the crossbar's slave ports and is used as an on-chip register/SRAM target and as a verification endpoint.

Parameters:
ID_W, 7, AW/B ID width; equals the crossbar slave-side ID width.
ADDR_W, 16, byte address width.
DATA_W, 32, W data width; power of 2, at least 8.
LEN_W, 4, burst length field width; beats = aw_len+1.
OT_DEPTH, 4, outstanding AW queue depth; power of 2, at least 2.
ADDR_LO, 16'h0000, lowest decoded byte address, inclusive.
ADDR_HI, 16'h0FFF, highest decoded byte address, inclusive.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
aw_valid  in  1  AW request valid
aw_ready  out  1  AW accept
aw_id  in  ID_W  transaction ID
aw_addr  in  ADDR_W  burst start byte address, INCR only
aw_len  in  LEN_W  beats minus 1
w_valid  in  1  W beat valid
w_ready  out  1  W accept
w_data  in  DATA_W  write data
w_last  in  1  master's last-beat marker
b_valid  out  1  response valid
b_ready  in  1  response accept
b_id  out  ID_W  echoed aw_id
b_resp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
mem_we  out  1  memory write strobe, one per in-range beat
mem_addr  out  ADDR_W  beat byte address
mem_wdata  out  DATA_W  beat data
err_cnt  out  8  saturating count of non-OKAY responses

Behaviour:
- Reset, synchronous on rst=1: the AW queue, beat counter, B slot and err_cnt clear. All outputs are 0 on the following cycle. An in-flight burst is dropped without a response. aw_ready rises the first cycle after rst deasserts.
- AW queue: a FIFO of OT_DEPTH entries holding {id, len, addr, decerr}.
  - aw_ready = !full.
  - No pass-through on full, even with a simultaneous pop.
  - decerr = (aw_addr < ADDR_LO) | (last beat address > ADDR_HI). Last beat address = aw_addr + aw_len*(DATA_W/8), computed at ADDR_W+1 bits so it cannot wrap.
- State machine, 2 states:
  - IDLE: queue empty, w_ready=0. Moves to DATA on the cycle after the first AW push; W cannot complete in the same cycle as its AW.
  - DATA: serves the queue head.
  - After the final beat, returns to IDLE if the queue is then empty, otherwise stays in DATA with the next head.
- W handshake:
  - w_ready = (state==DATA) & (beat<len | !b_valid | b_ready).
  - The final beat stalls only while an unaccepted response occupies the single B slot.
  - W beats arriving before their AW are held off by w_ready=0.
- Beat handling:
  - beat counter starts at 0 and increments per accepted beat.
  - The burst ends when beat==len is accepted, regardless of w_last.
  - w_last mismatch (asserted at beat<len, or deasserted at beat==len) sets a per-burst SLVERR flag.
- Memory port:
  - On each accepted beat, mem_we=1 the next cycle (1-cycle registered) when the burst is not decerr.
  - mem_addr = head addr + beat*(DATA_W/8); mem_wdata = w_data.
  - mem_we=0 otherwise, and for decerr bursts.
- B response:
  - Registered: b_valid rises the cycle after the final beat handshake.
  - b_id = head id.
  - b_resp: DECERR if decerr; else SLVERR if the mismatch flag is set; else OKAY.
  - b_valid/b_id/b_resp are held stable until b_ready. The B slot clears on the b_valid & b_ready cycle; a new response may load in that same cycle.
- Queue pop: on the final beat handshake.
- err_cnt: increments when a non-OKAY response is loaded into the B slot; saturates at 255.

Test Plan:
- Single write: AW id=7'h25, addr=16'h0100, len=0, W data=32'hDEADBEEF with last=1, b_ready=1 → mem_we=1, mem_addr=16'h0100; b_valid 1 cycle after the W handshake; b_id=7'h25, b_resp=00.
- Burst: len=3, addr=16'h0200, 4 beats → mem_addr 0200/0204/0208/020C on consecutive writes; exactly one B with OKAY.
- Errors:
  - addr=16'h0FFC, len=1 → DECERR, no mem_we, err_cnt=1.
  - In-range len=2 burst with w_last on beat 1 → SLVERR, 3 mem writes, err_cnt=2.
- Backpressure: 5 AWs with b_ready=0 → aw_ready drops after 4 queued. The final beat of burst 2 stalls until b_ready. Responses return in AW order with IDs intact.
- W-before-AW and reset: w_valid high for 3 cycles before AW → w_ready stays 0. Then assert rst mid-burst (beat 1 of len=3) → next cycle b_valid=0, mem_we=0, err_cnt=0, queue empty, no B is issued.
